// File: rtl/assoc_buffer_ctrl.sv
// Key/value associative buffer with a sequential one-entry-per-cycle search/insert engine.
// Also drives ctrl/data_input of a downstream result register (LOAD on search hit, CLR on flush).
module assoc_buffer_ctrl #(
    parameter int unsigned KEY_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ENTRIES    = 4,
    parameter int unsigned IDX_WIDTH  = $clog2(ENTRIES),
    parameter int unsigned CTRL_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [KEY_WIDTH-1:0]  cmd_key,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [IDX_WIDTH-1:0]  rsp_idx,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [CTRL_WIDTH-1:0] CTRL_NONE = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_CLR  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CTRL_LOAD = CTRL_WIDTH'(2);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_RESP} state_e;

    state_e                state_q;
    logic [ENTRIES-1:0]    valid_q;
    logic [KEY_WIDTH-1:0]  key_q [ENTRIES];
    logic [DATA_WIDTH-1:0] val_q [ENTRIES];
    logic [IDX_WIDTH-1:0]  rep_ptr_q;

    logic                  op_q;
    logic [KEY_WIDTH-1:0]  ckey_q;
    logic [DATA_WIDTH-1:0] cdata_q;
    logic [IDX_WIDTH-1:0]  scan_idx_q;
    logic                  free_found_q;
    logic [IDX_WIDTH-1:0]  free_idx_q;
    logic                  match_q;
    logic [IDX_WIDTH-1:0]  match_idx_q;

    logic                  res_hit_q;
    logic [IDX_WIDTH-1:0]  res_idx_q;
    logic [DATA_WIDTH-1:0] res_data_q;

    logic                  rsp_valid_q;
    logic                  rsp_hit_q;
    logic [IDX_WIDTH-1:0]  rsp_idx_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic                  entry_match_c;
    logic                  scan_last_c;
    logic                  free_found_c;
    logic [IDX_WIDTH-1:0]  free_idx_c;
    logic [IDX_WIDTH-1:0]  wr_idx_c;

    // Free-slot tracker includes the entry under compare so the last slot is not missed
    always_comb begin
        entry_match_c = valid_q[scan_idx_q] && (key_q[scan_idx_q] == ckey_q);
        scan_last_c   = (scan_idx_q == IDX_WIDTH'(ENTRIES - 1));
        free_found_c  = free_found_q || !valid_q[scan_idx_q];
        free_idx_c    = free_found_q ? free_idx_q : scan_idx_q;
        wr_idx_c      = match_q ? match_idx_q : (free_found_q ? free_idx_q : rep_ptr_q);
    end

    assign cmd_ready = (state_q == S_IDLE) && !flush;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_data  = rsp_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            rep_ptr_q    <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            op_q         <= 1'b0;
            ckey_q       <= '0;
            cdata_q      <= '0;
            scan_idx_q   <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            match_q      <= 1'b0;
            match_idx_q  <= '0;
            res_hit_q    <= 1'b0;
            res_idx_q    <= '0;
            res_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_idx_q    <= '0;
            rsp_data_q   <= '0;
            out_ctrl_q   <= CTRL_NONE;
            out_data_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_NONE;
            case (state_q)
                S_IDLE: begin
                    // Flush wins over a simultaneous command
                    if (flush) begin
                        valid_q    <= '0;
                        rep_ptr_q  <= '0;
                        out_ctrl_q <= CTRL_CLR;
                    end else if (cmd_valid) begin
                        op_q         <= cmd_op;
                        ckey_q       <= cmd_key;
                        cdata_q      <= cmd_data;
                        scan_idx_q   <= '0;
                        free_found_q <= 1'b0;
                        free_idx_q   <= '0;
                        match_q      <= 1'b0;
                        match_idx_q  <= '0;
                        state_q      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    free_found_q <= free_found_c;
                    free_idx_q   <= free_idx_c;
                    if (entry_match_c || scan_last_c) begin
                        match_q     <= entry_match_c;
                        match_idx_q <= scan_idx_q;
                        if (op_q) begin
                            state_q <= S_WRITE;
                        end else begin
                            res_hit_q  <= entry_match_c;
                            res_idx_q  <= entry_match_c ? scan_idx_q : '0;
                            res_data_q <= entry_match_c ? val_q[scan_idx_q] : '0;
                            state_q    <= S_RESP;
                        end
                    end else begin
                        scan_idx_q <= scan_idx_q + IDX_WIDTH'(1);
                    end
                end
                S_WRITE: begin
                    key_q[wr_idx_c]   <= ckey_q;
                    val_q[wr_idx_c]   <= cdata_q;
                    valid_q[wr_idx_c] <= 1'b1;
                    // Replacement pointer only advances when an occupied entry is evicted
                    if (!match_q && !free_found_q) begin
                        rep_ptr_q <= rep_ptr_q + IDX_WIDTH'(1);
                    end
                    res_hit_q  <= match_q;
                    res_idx_q  <= wr_idx_c;
                    res_data_q <= cdata_q;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_hit_q   <= res_hit_q;
                    rsp_idx_q   <= res_idx_q;
                    rsp_data_q  <= res_data_q;
                    if (!op_q && res_hit_q) begin
                        out_ctrl_q <= CTRL_LOAD;
                        out_data_q <= res_data_q;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_buffer_ctrl.sv
// Self-checking bench for assoc_buffer_ctrl: table-driven command records through a
// response scoreboard, plus hand-written flush and mid-scan reset sequences.
module tb_assoc_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] cmd_key;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [1:0] rsp_idx;
    logic [7:0] rsp_data;
    logic [1:0] out_ctrl;
    logic [7:0] out_data;

    int errors = 0;
    int checks = 0;

    assoc_buffer_ctrl #(
        .KEY_WIDTH (8),
        .DATA_WIDTH(8),
        .ENTRIES   (4),
        .IDX_WIDTH (2),
        .CTRL_WIDTH(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_key  (cmd_key),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_hit  (rsp_hit),
        .rsp_idx  (rsp_idx),
        .rsp_data (rsp_data),
        .out_ctrl (out_ctrl),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [7:0] key;
        logic [7:0] data;
        logic       hit;
        logic [1:0] idx;
        logic [7:0] rdata;
        int         lat;
        logic [1:0] ctrl;
    } rec_t;

    rec_t tbl_a[$];
    rec_t tbl_b[$];
    rec_t sb[$];

    function automatic rec_t mk(input logic op, input logic [7:0] key, input logic [7:0] data,
                                input logic hit, input logic [1:0] idx, input logic [7:0] rdata,
                                input int lat, input logic [1:0] ctrl);
        rec_t r;
        r.op = op; r.key = key; r.data = data; r.hit = hit; r.idx = idx;
        r.rdata = rdata; r.lat = lat; r.ctrl = ctrl;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one command, push its expectation, then pop and compare at the response
    task automatic run_cmd(input rec_t r, input int n);
        rec_t e;
        int   cyc;
        string tag;
        tag = $sformatf("cmd%0d", n);
        sb.push_back(r);
        @(negedge clk);
        check({tag, ".ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = r.op; cmd_key = r.key; cmd_data = r.data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        check({tag, ".rsp_valid"}, int'(rsp_valid), 1);
        check({tag, ".latency"}, cyc, e.lat);
        check({tag, ".hit"}, int'(rsp_hit), int'(e.hit));
        check({tag, ".idx"}, int'(rsp_idx), int'(e.idx));
        check({tag, ".data"}, int'(rsp_data), int'(e.rdata));
        check({tag, ".out_ctrl"}, int'(out_ctrl), int'(e.ctrl));
        if (e.ctrl == 2'd2) check({tag, ".out_data"}, int'(out_data), int'(e.rdata));
        @(posedge clk); #1;
        check({tag, ".pulse_end"}, int'(rsp_valid), 0);
        check({tag, ".hold_data"}, int'(rsp_data), int'(e.rdata));
    endtask

    initial begin
        int seen;
        rst = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_key = '0; cmd_data = '0;

        // op, key, data, hit, idx, rdata, latency, out_ctrl
        tbl_a.push_back(mk(0, 8'h11, 8'h00, 0, 2'd0, 8'h00, 5, 2'd0));
        tbl_a.push_back(mk(1, 8'h11, 8'hA5, 0, 2'd0, 8'hA5, 6, 2'd0));
        tbl_a.push_back(mk(0, 8'h11, 8'h00, 1, 2'd0, 8'hA5, 2, 2'd2));
        tbl_a.push_back(mk(1, 8'h11, 8'h5A, 1, 2'd0, 8'h5A, 3, 2'd0));
        tbl_a.push_back(mk(0, 8'h11, 8'h00, 1, 2'd0, 8'h5A, 2, 2'd2));

        tbl_b.push_back(mk(0, 8'h11, 8'h00, 0, 2'd0, 8'h00, 5, 2'd0));
        tbl_b.push_back(mk(1, 8'h10, 8'h50, 0, 2'd0, 8'h50, 6, 2'd0));
        tbl_b.push_back(mk(1, 8'h11, 8'h51, 0, 2'd1, 8'h51, 6, 2'd0));
        tbl_b.push_back(mk(1, 8'h12, 8'h52, 0, 2'd2, 8'h52, 6, 2'd0));
        tbl_b.push_back(mk(1, 8'h13, 8'h53, 0, 2'd3, 8'h53, 6, 2'd0));
        tbl_b.push_back(mk(0, 8'h13, 8'h00, 1, 2'd3, 8'h53, 5, 2'd2));
        tbl_b.push_back(mk(1, 8'h20, 8'h60, 0, 2'd0, 8'h60, 6, 2'd0));
        tbl_b.push_back(mk(1, 8'h21, 8'h61, 0, 2'd1, 8'h61, 6, 2'd0));
        tbl_b.push_back(mk(0, 8'h10, 8'h00, 0, 2'd0, 8'h00, 5, 2'd0));
        tbl_b.push_back(mk(0, 8'h20, 8'h00, 1, 2'd0, 8'h60, 2, 2'd2));
        tbl_b.push_back(mk(0, 8'h21, 8'h00, 1, 2'd1, 8'h61, 3, 2'd2));
        tbl_b.push_back(mk(1, 8'h13, 8'h77, 1, 2'd3, 8'h77, 6, 2'd0));
        tbl_b.push_back(mk(1, 8'h22, 8'h62, 0, 2'd2, 8'h62, 6, 2'd0));
        tbl_b.push_back(mk(1, 8'h23, 8'h63, 0, 2'd3, 8'h63, 6, 2'd0));
        tbl_b.push_back(mk(1, 8'h24, 8'h64, 0, 2'd0, 8'h64, 6, 2'd0));
        tbl_b.push_back(mk(0, 8'h24, 8'h00, 1, 2'd0, 8'h64, 2, 2'd2));
        tbl_b.push_back(mk(0, 8'h13, 8'h00, 0, 2'd0, 8'h00, 5, 2'd0));

        repeat (2) @(posedge clk);
        #1;
        check("reset.rsp_valid", int'(rsp_valid), 0);
        check("reset.rsp_hit", int'(rsp_hit), 0);
        check("reset.rsp_idx", int'(rsp_idx), 0);
        check("reset.rsp_data", int'(rsp_data), 0);
        check("reset.out_ctrl", int'(out_ctrl), 0);
        check("reset.out_data", int'(out_data), 0);
        @(negedge clk) rst = 1'b1;
        #1 check("reset.cmd_ready", int'(cmd_ready), 1);

        foreach (tbl_a[i]) run_cmd(tbl_a[i], i);

        // Flush with a simultaneous command: flush wins, CLR for one cycle
        @(negedge clk);
        flush = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = 8'h11;
        #1 check("flush.cmd_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; cmd_valid = 1'b0;
        check("flush.out_ctrl_clr", int'(out_ctrl), 1);
        @(posedge clk); #1;
        check("flush.out_ctrl_none", int'(out_ctrl), 0);
        check("flush.no_rsp", int'(rsp_valid), 0);
        check("flush.ready_after", int'(cmd_ready), 1);

        foreach (tbl_b[i]) run_cmd(tbl_b[i], 100 + i);

        // Reset asserted mid-scan: the pending command is dropped, no response pulse
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = 8'h24;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        seen = 0;
        @(negedge clk) rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        @(negedge clk) rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("midreset.no_rsp", seen, 0);
        check("midreset.cmd_ready", int'(cmd_ready), 1);
        check("midreset.rsp_data", int'(rsp_data), 0);
        check("midreset.out_ctrl", int'(out_ctrl), 0);
        run_cmd(mk(0, 8'h24, 8'h00, 0, 2'd0, 8'h00, 5, 2'd0), 200);
        run_cmd(mk(0, 8'h21, 8'h00, 0, 2'd0, 8'h00, 5, 2'd0), 201);

        check("scoreboard.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
